// File: rtl/arch_maptable_pkg.sv
// Shared definitions for the architectural map table: widths, the committed
// map type shared with the retire stage, and a small popcount helper.
package arch_maptable_pkg;

  localparam int XLEN = 64;           // machine word / counter width
  localparam int PR_W = 6;            // physical register index width
  localparam int AR_N = 32;           // architectural integer registers
  localparam int AR_W = 5;            // architectural register index width
  localparam int WAYS = 3;            // retire width
  localparam int CNT_W = 2;           // enough to hold 0..WAYS

  // Committed arch -> phys mapping. The retire stage builds its
  // recover_maptable from the same type.
  typedef logic [AR_N-1:0][PR_W-1:0] ARCH_MAP_T;

  typedef logic [WAYS-1:0][AR_W-1:0] way_ar_t;
  typedef logic [WAYS-1:0][PR_W-1:0] way_pr_t;

  // Number of ways retiring this cycle.
  function automatic logic [CNT_W-1:0] popcount_ways(input logic [WAYS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WAYS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/maptable_wr_sel.sv
// Per-architectural-register write select: for every AR, find the youngest
// enabled retire way that targets it and return (hit, pr). Way WAYS-1 is the
// oldest and way 0 the youngest. AR0 never hits.
module maptable_wr_sel
  import arch_maptable_pkg::*;
(
  input  logic [WAYS-1:0] i_en,
  input  way_ar_t         i_ar,
  input  way_pr_t         i_pr,
  output logic [AR_N-1:0] o_hit,
  output ARCH_MAP_T       o_pr
);

  // Scan oldest to youngest so the youngest matching way overwrites last.
  always_comb begin
    // NOTE: every output gets a default before the loops; without it any AR
    // left unassigned on some path would infer a latch.
    o_hit = '0;
    o_pr  = '0;
    for (int a = 1; a < AR_N; a++) begin
      for (int k = WAYS - 1; k >= 0; k--) begin
        if (i_en[k] && (i_ar[k] == AR_W'(a))) begin
          o_hit[a] = 1'b1;
          o_pr[a]  = i_pr[k];
        end
      end
    end
  end

endmodule

// File: rtl/arch_maptable.sv
// Architectural (retirement) map table. Holds the committed AR -> PR mapping,
// updated by up to WAYS retiring instructions per cycle, plus a committed
// instruction counter and a sticky mapping-consistency flag. The table output
// is purely registered; the retire stage merges in-flight writes itself.
// BPRecoverEN has no effect here: the retire stage already masks younger ways,
// so whatever is enabled in a recovery cycle commits normally. Under
// TEST_MODE the registered table output also serves as the display view.
module arch_maptable
  import arch_maptable_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,        // synchronous, active-low
  input  logic [WAYS-1:0]      Retire_EN,
  input  way_ar_t              map_ar,
  input  way_pr_t              map_ar_pr,
  input  logic                 BPRecoverEN,
  output ARCH_MAP_T            archi_maptable,
  output logic [XLEN-1:0]      instret,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic                 dup_err
);

  ARCH_MAP_T         r_map;
  logic [XLEN-1:0]   r_instret;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic              r_dup_err;

  logic [AR_N-1:0]   w_hit;
  ARCH_MAP_T         w_sel_pr;
  ARCH_MAP_T         w_next_map;
  logic              w_dup_hit;
  logic [CNT_W-1:0]  w_retire_n;
  logic              w_unused_bp;

  // Recovery is handled upstream; keep the input visibly consumed.
  assign w_unused_bp = BPRecoverEN;

  maptable_wr_sel u_wr_sel (
    .i_en  (Retire_EN),
    .i_ar  (map_ar),
    .i_pr  (map_ar_pr),
    .o_hit (w_hit),
    .o_pr  (w_sel_pr)
  );

  assign w_retire_n = popcount_ways(Retire_EN);

  // Post-update table: selected PR where a way hit, otherwise hold.
  always_comb begin
    w_next_map = r_map;
    for (int a = 1; a < AR_N; a++) begin
      if (w_hit[a]) begin
        w_next_map[a] = w_sel_pr[a];
      end
    end
    w_next_map[0] = '0;
  end

  // Flag a committed PR that, after the update, also sits under another live AR.
  // Checking post-update state lets a PR move between ARs within one bundle.
  always_comb begin
    w_dup_hit = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (Retire_EN[k] && (map_ar[k] != '0)) begin
        for (int b = 1; b < AR_N; b++) begin
          if ((AR_W'(b) != map_ar[k]) && (w_next_map[b] == map_ar_pr[k])) begin
            w_dup_hit = 1'b1;
          end
        end
      end
    end
  end

  // Committed state: table, counters and sticky error; reset restores identity.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      // NOTE: the table is reset (not left uninitialised like a RAM) because
      // the identity map is the architectural starting state.
      for (int i = 0; i < AR_N; i++) begin
        r_map[i] <= PR_W'(i);
      end
      r_instret    <= '0;
      r_retire_cnt <= '0;
      r_dup_err    <= 1'b0;
    end else begin
      r_map        <= w_next_map;
      r_instret    <= r_instret + XLEN'(w_retire_n);
      r_retire_cnt <= w_retire_n;
      r_dup_err    <= r_dup_err | w_dup_hit;
    end
  end

  assign archi_maptable = r_map;
  assign instret        = r_instret;
  assign retire_cnt     = r_retire_cnt;
  assign dup_err        = r_dup_err;

endmodule

// File: tb/tb_arch_maptable.sv
// Self-checking bench for arch_maptable: a spec-level model is compared
// against the DUT every cycle, and literal expectations pin key points.
module tb_arch_maptable;
  import arch_maptable_pkg::*;

  logic                clock;
  logic                reset;
  logic [WAYS-1:0]     Retire_EN;
  way_ar_t             map_ar;
  way_pr_t             map_ar_pr;
  logic                BPRecoverEN;
  ARCH_MAP_T           archi_maptable;
  logic [XLEN-1:0]     instret;
  logic [CNT_W-1:0]    retire_cnt;
  logic                dup_err;

  arch_maptable dut (
    .clock          (clock),
    .reset          (reset),
    .Retire_EN      (Retire_EN),
    .map_ar         (map_ar),
    .map_ar_pr      (map_ar_pr),
    .BPRecoverEN    (BPRecoverEN),
    .archi_maptable (archi_maptable),
    .instret        (instret),
    .retire_cnt     (retire_cnt),
    .dup_err        (dup_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer array and counters.
  int          m_map [AR_N];
  longint unsigned m_instret;
  int          m_cnt;
  bit          m_dup;
  bit          model_valid = 1'b0;

  task automatic model_step(input bit rst_n, input logic [2:0] en,
                            input way_ar_t ar, input way_pr_t pr);
    int nm [AR_N];
    int n;
    if (!rst_n) begin
      for (int i = 0; i < AR_N; i++) m_map[i] = i;
      m_instret = 0;
      m_cnt = 0;
      m_dup = 0;
      model_valid = 1'b1;
      return;
    end
    nm = m_map;
    n = 0;
    // Retire in program order: oldest way (2) first, youngest last.
    for (int k = 2; k >= 0; k--) begin
      if (en[k]) begin
        n++;
        if (ar[k] != 0) nm[ar[k]] = int'(pr[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (en[k] && ar[k] != 0) begin
        for (int b = 1; b < AR_N; b++) begin
          if (b != int'(ar[k]) && nm[b] == int'(pr[k])) m_dup = 1;
        end
      end
    end
    m_map = nm;
    m_cnt = n;
    m_instret = m_instret + longint'(n);
  endtask

  // Compare process: every negedge once the model has seen a reset.
  always @(negedge clock) begin
    if (model_valid) begin
      for (int i = 0; i < AR_N; i++) begin
        check($sformatf("map[%0d]", i), 64'(archi_maptable[i]), 64'(m_map[i]));
      end
      check("instret", instret, m_instret);
      check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
      check("dup_err", 64'(dup_err), 64'(m_dup));
    end
  end

  // Apply one cycle of stimulus; returns just after the posedge.
  task automatic drive(input bit rst_n, input logic [2:0] en, input way_ar_t ar,
                       input way_pr_t pr, input bit bp);
    @(negedge clock);
    #1;
    reset       = rst_n;
    Retire_EN   = en;
    map_ar      = ar;
    map_ar_pr   = pr;
    BPRecoverEN = bp;
    @(posedge clock);
    model_step(rst_n, en, ar, pr);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 3'b000, {5'd31, 5'd30, 5'd29}, {6'd63, 6'd62, 6'd61}, 1'b0);
  endtask

  initial begin
    reset = 1'b0; Retire_EN = '0; map_ar = '0; map_ar_pr = '0; BPRecoverEN = 1'b0;

    // Reset, then idle two cycles.
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    idle();
    idle();
    check("lit_rst_map31", 64'(archi_maptable[31]), 64'd31);
    check("lit_rst_map0", 64'(archi_maptable[0]), 64'd0);
    check("lit_rst_instret", instret, 64'd0);
    check("lit_rst_dup", 64'(dup_err), 64'd0);

    // Three distinct ARs.
    drive(1'b1, 3'b111, {5'd1, 5'd2, 5'd3}, {6'd32, 6'd33, 6'd34}, 1'b0);
    check("lit_t1_ar1", 64'(archi_maptable[1]), 64'd32);
    check("lit_t1_ar3", 64'(archi_maptable[3]), 64'd34);
    check("lit_t1_ar4", 64'(archi_maptable[4]), 64'd4);
    check("lit_t1_cnt", 64'(retire_cnt), 64'd3);
    check("lit_t1_instret", instret, 64'd3);

    // All ways to AR5: youngest (way 0) wins.
    drive(1'b1, 3'b111, {5'd5, 5'd5, 5'd5}, {6'd40, 6'd41, 6'd42}, 1'b0);
    check("lit_t2_ar5", 64'(archi_maptable[5]), 64'd42);
    check("lit_t2_instret", instret, 64'd6);

    // Non-contiguous enable with an AR0 write; disabled way must not write.
    drive(1'b1, 3'b101, {5'd0, 5'd7, 5'd9}, {6'd45, 6'd46, 6'd47}, 1'b0);
    check("lit_t3_ar0", 64'(archi_maptable[0]), 64'd0);
    check("lit_t3_ar9", 64'(archi_maptable[9]), 64'd47);
    check("lit_t3_ar7", 64'(archi_maptable[7]), 64'd7);
    check("lit_t3_cnt", 64'(retire_cnt), 64'd2);
    check("lit_t3_instret", instret, 64'd8);

    // PR32 moves from AR1 to AR2 within one bundle: not a duplicate.
    drive(1'b1, 3'b101, {5'd1, 5'd20, 5'd2}, {6'd60, 6'd21, 6'd32}, 1'b0);
    check("lit_mv_ar1", 64'(archi_maptable[1]), 64'd60);
    check("lit_mv_ar2", 64'(archi_maptable[2]), 64'd32);
    check("lit_mv_dup", 64'(dup_err), 64'd0);

    // Recovery cycle: enabled ways still commit, no flush.
    drive(1'b1, 3'b110, {5'd10, 5'd11, 5'd12}, {6'd50, 6'd51, 6'd52}, 1'b1);
    check("lit_bp_ar10", 64'(archi_maptable[10]), 64'd50);
    check("lit_bp_ar11", 64'(archi_maptable[11]), 64'd51);
    check("lit_bp_ar12", 64'(archi_maptable[12]), 64'd12);
    check("lit_bp_ar9", 64'(archi_maptable[9]), 64'd47);
    check("lit_bp_instret", instret, 64'd12);
    idle();

    // Reset in the same cycle as a write: reset wins.
    drive(1'b0, 3'b111, {5'd12, 5'd13, 5'd14}, {6'd55, 6'd56, 6'd57}, 1'b0);
    check("lit_rw_ar12", 64'(archi_maptable[12]), 64'd12);
    check("lit_rw_ar10", 64'(archi_maptable[10]), 64'd10);
    check("lit_rw_instret", instret, 64'd0);
    idle();

    // PR6 committed to AR4 while AR6 still holds PR6: sticky error.
    drive(1'b1, 3'b001, {5'd0, 5'd0, 5'd4}, {6'd0, 6'd0, 6'd6}, 1'b0);
    check("lit_dup_set", 64'(dup_err), 64'd1);
    idle();
    idle();
    check("lit_dup_sticky", 64'(dup_err), 64'd1);
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    check("lit_dup_clr", 64'(dup_err), 64'd0);
    check("lit_dup_ar4", 64'(archi_maptable[4]), 64'd4);
    idle();
    idle();

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
